multiword_add_seq: RTL and testbench

//  Sequencer that performs one WORDS*16-bit add on a single 16-bit add stage
//    (the adder16 datapath: 16-bit operands, carry out), one limb per cycle, LSB limb first.

---
 rtl/multiword_add_seq_if.sv | 44 ++++
 rtl/multiword_add_seq.sv | 121 ++++++++++++
 tb/tb_multiword_add_seq.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multiword_add_seq_if.sv
// Handshake bundle for multiword_add_seq.
//   in_valid/in_ready   operand-side valid/ready
//   in_a/in_b           operands, 16*WORDS bits
//   in_sub              subtract request (only with MULTIWORD_ADD_SUB_EN)
//   busy                operation in progress
//   out_valid/out_ready result-side valid/ready
//   out_sum/out_c_out   result and carry out of the top limb
// master: producer/consumer side. slave: the sequencer.
interface multiword_add_seq_if #(
  parameter int unsigned WORDS = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [16*WORDS-1:0]  in_a;
  logic [16*WORDS-1:0]  in_b;
`ifdef MULTIWORD_ADD_SUB_EN
  logic                 in_sub;
`endif
  logic                 busy;
  logic                 out_valid;
  logic                 out_ready;
  logic [16*WORDS-1:0]  out_sum;
  logic                 out_c_out;

`ifdef MULTIWORD_ADD_SUB_EN
  modport master (
    output in_valid, in_a, in_b, in_sub, out_ready,
    input  in_ready, busy, out_valid, out_sum, out_c_out
  );
  modport slave (
    input  in_valid, in_a, in_b, in_sub, out_ready,
    output in_ready, busy, out_valid, out_sum, out_c_out
  );
`else
  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, busy, out_valid, out_sum, out_c_out
  );
  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, busy, out_valid, out_sum, out_c_out
  );
`endif
endinterface

// File: rtl/multiword_add_seq.sv
// Multi-limb adder sequencer: one WORDS*16-bit add performed on a single 16-bit add
// stage, one limb per cycle, LSB limb first, carry registered between limbs.
// Optional feature macro: MULTIWORD_ADD_SUB_EN adds in_sub (A-B as A+~B+1).
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    multiword_add_seq_if.slave (operand handshake, result handshake, busy)
// WORDS: number of 16-bit limbs, legal range 2..16.
module multiword_add_seq #(
  parameter int unsigned WORDS = 4
) (
  input logic               clk,
  input logic               reset,
  multiword_add_seq_if.slave bus
);
  localparam int unsigned IdxW = $clog2(WORDS);
  localparam int unsigned W    = 16 * WORDS;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            c_out_q, c_out_d;
`ifdef MULTIWORD_ADD_SUB_EN
  logic            sub_q, sub_d;
`endif

  logic [15:0] limb_a, limb_b;
  logic [16:0] limb_sum;

  // The single 16-bit add stage, fed by the limb selected by idx_q.
  always_comb begin
    limb_a = a_q[idx_q*16 +: 16];
    limb_b = b_q[idx_q*16 +: 16];
`ifdef MULTIWORD_ADD_SUB_EN
    if (sub_q) limb_b = ~limb_b;
`endif
    limb_sum = {1'b0, limb_a} + {1'b0, limb_b} + {16'd0, carry_q};
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
`ifdef MULTIWORD_ADD_SUB_EN
    sub_d   = sub_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d   = bus.in_a;
          b_d   = bus.in_b;
          sum_d = '0;
          idx_d = '0;
`ifdef MULTIWORD_ADD_SUB_EN
          sub_d   = bus.in_sub;
          // Initial carry of 1 completes the two's complement of B.
          carry_d = bus.in_sub;
`else
          carry_d = 1'b0;
`endif
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[idx_q*16 +: 16] = limb_sum[15:0];
        carry_d               = limb_sum[16];
        if (idx_q == IdxW'(WORDS - 1)) begin
          c_out_d = limb_sum[16];
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
`ifdef MULTIWORD_ADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
`ifdef MULTIWORD_ADD_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.busy      = (state_q == StRun);
  assign bus.out_valid = (state_q == StDone);
  assign bus.out_sum   = sum_q;
  assign bus.out_c_out = c_out_q;
endmodule

// File: tb/tb_multiword_add_seq.sv
// Bench for multiword_add_seq: directed cases, randomized operations with random
// consumer back-pressure, and a per-cycle monitor against an arithmetic model.
`timescale 1ns/1ps
module tb_multiword_add_seq;
  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = 16 * WORDS;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multiword_add_seq_if #(.WORDS(WORDS)) bus ();

  multiword_add_seq #(.WORDS(WORDS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic sub_v = 1'b0;
`ifdef MULTIWORD_ADD_SUB_EN
  assign bus.in_sub = sub_v;
`endif

  int checks = 0;
  int errors = 0;

  // Reference: whole-width arithmetic, {carry, sum}.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic s);
    logic [W-1:0] bb;
    bb = s ? ~b : b;
    return {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, s};
  endfunction

  task automatic chk(input string name, input logic [W:0] got, input logic [W:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting, got no event expected one", name);
  endtask

  // Monitor state: at most one operation outstanding.
  bit           mon_en  = 1'b0;
  bit           pending = 1'b0;
  logic [W:0]   exp_r;
  int           cyc     = 0;
  int           due     = 0;
  bit           rand_rdy = 1'b0;

  always @(negedge clk) begin
    logic s;
    cyc++;
    if (mon_en) begin
      chk("mon_in_ready", {{W{1'b0}}, bus.in_ready}, {{W{1'b0}}, !pending});
      if (!pending) begin
        chk("mon_idle_valid", {{W{1'b0}}, bus.out_valid}, '0);
        chk("mon_idle_busy",  {{W{1'b0}}, bus.busy},      '0);
      end else if (cyc < due) begin
        chk("mon_run_valid", {{W{1'b0}}, bus.out_valid}, '0);
        chk("mon_run_busy",  {{W{1'b0}}, bus.busy},      (W+1)'(1));
      end else begin
        chk("mon_done_valid", {{W{1'b0}}, bus.out_valid}, (W+1)'(1));
        chk("mon_done_busy",  {{W{1'b0}}, bus.busy},      '0);
        chk("mon_sum",   {1'b0, bus.out_sum},          {1'b0, exp_r[W-1:0]});
        chk("mon_c_out", {{W{1'b0}}, bus.out_c_out},   {{W{1'b0}}, exp_r[W]});
      end
      if (reset) begin
        pending = 1'b0;
      end else if (pending && cyc >= due && bus.out_ready) begin
        pending = 1'b0;
      end else if (!pending && bus.in_valid) begin
`ifdef MULTIWORD_ADD_SUB_EN
        s = bus.in_sub;
`else
        s = 1'b0;
`endif
        exp_r   = model(bus.in_a, bus.in_b, s);
        due     = cyc + WORDS + 1;
        pending = 1'b1;
      end
    end
  end

  // Random consumer back-pressure when enabled.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    bus.in_a     = a;
    bus.in_b     = b;
    sub_v        = s;
    bus.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.in_ready && !reset) break;
      n++;
      if (n > 100) begin
        timeout("send_accept");
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    // Operands may change freely after the accept edge.
    bus.in_a = {$urandom, $urandom};
    bus.in_b = {$urandom, $urandom};
  endtask

  task automatic wait_result(input string name, input logic [W-1:0] es, input logic ec,
                             output int n);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (bus.out_valid) break;
      if (n > 50) begin
        timeout({name, "_valid"});
        break;
      end
    end
    chk({name, "_sum"},   {1'b0, bus.out_sum},        {1'b0, es});
    chk({name, "_c_out"}, {{W{1'b0}}, bus.out_c_out}, {{W{1'b0}}, ec});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [W-1:0] snap;
    logic [W-1:0] ra, rb;
    logic rs;

    // Model pins.
    chk("pin_model_carry", model(64'h0000_0000_0000_FFFF, 64'd1, 1'b0),
        65'h0_0000_0000_0001_0000);
    chk("pin_model_wrap",  model(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0), 65'h1_0000_0000_0000_0000);
    chk("pin_model_sub",   model(64'd5, 64'd7, 1'b1), 65'h0_FFFF_FFFF_FFFF_FFFE);
    chk("pin_model_sub2",  model(64'd7, 64'd5, 1'b1), 65'h1_0000_0000_0000_0002);

    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_sum",       {1'b0, bus.out_sum},          '0);
    chk("rst_c_out",     {{W{1'b0}}, bus.out_c_out},   '0);
    chk("rst_out_valid", {{W{1'b0}}, bus.out_valid},   '0);
    chk("rst_busy",      {{W{1'b0}}, bus.busy},        '0);
    chk("rst_in_ready",  {{W{1'b0}}, bus.in_ready},    (W+1)'(1));

    // 1: zero operands, latency.
    bus.out_ready = 1'b1;
    send(64'd0, 64'd0, 1'b0);
    wait_result("t1", 64'd0, 1'b0, n);
    chk("t1_latency", (W+1)'(n), (W+1)'(WORDS + 1));

    // 2: carry between limbs.
    send(64'h0000_0000_0000_FFFF, 64'd1, 1'b0);
    wait_result("t2", 64'h0000_0000_0001_0000, 1'b0, n);

    // 3: full ripple with carry out.
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    wait_result("t3", 64'd0, 1'b1, n);

    // 4: stall in DONE, ignored in_valid pulse, then second pair after handshake.
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send(64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0);
    wait_result("t4a", 64'h2143_6587_A9CB_EDFF, 1'b0, n);
    snap = bus.out_sum;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = (i == 0);
      bus.in_a     = 64'h1111_1111_1111_1111;
      bus.in_b     = 64'h2222_2222_2222_2222;
      @(negedge clk);
      chk("t4_stable_sum", {1'b0, bus.out_sum},        {1'b0, snap});
      chk("t4_in_ready",   {{W{1'b0}}, bus.in_ready},  '0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0);
    wait_result("t4b", 64'h3333_3333_3333_3333, 1'b0, n);

    // 5: reset during the second RUN cycle.
    send(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t5_out_valid", {{W{1'b0}}, bus.out_valid}, '0);
    chk("t5_busy",      {{W{1'b0}}, bus.busy},      '0);
    chk("t5_in_ready",  {{W{1'b0}}, bus.in_ready},  (W+1)'(1));
    send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
    wait_result("t5", 64'd0, 1'b1, n);

`ifdef MULTIWORD_ADD_SUB_EN
    // 6: subtraction.
    send(64'd5, 64'd7, 1'b1);
    wait_result("t6a", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, n);
    send(64'd7, 64'd5, 1'b1);
    wait_result("t6b", 64'd2, 1'b1, n);
`endif

    // Randomized operations with random back-pressure; the monitor checks each one.
    rand_rdy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (k % 5 == 0) rb = ~ra;
`ifdef MULTIWORD_ADD_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      send(ra, rb, rs);
    end
    @(posedge clk);
    #1;
    rand_rdy      = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while (pending && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (pending) timeout("drain");
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
